// File: rtl/controlador_execucao.sv
// controlador_execucao: PC/commit gating for run, IN/OUT button stall and HALT,
// with an internal push-button synchroniser and debouncer.
module controlador_execucao #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] enable_clock,
  input  logic       halt,
  input  logic       button,
  output logic       pc_enable,
  output logic       commit,
  output logic       out_strobe,
  output logic       waiting,
  output logic       halted
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {RUN, WAIT_PRESS, COMMIT, WAIT_RELEASE, HALTED} state_t;

  state_t        state_q, state_d;
  logic [1:0]    sync_q;
  logic          deb_q, deb_d, deb_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_evt, in_run;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RUN;
      sync_q     <= 2'b11;
      deb_q      <= 1'b1;
      deb_prev_q <= 1'b1;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[0], button};
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync_q[1] != deb_q) begin
      if (cnt_q == CNT_MAX) deb_d = sync_q[1];
      else cnt_d = cnt_q + 1'b1;
    end
  end

  assign press_evt = deb_prev_q & ~deb_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:          state_d = halt ? HALTED : (!enable_clock[0] ? WAIT_PRESS : RUN);
      WAIT_PRESS:   state_d = press_evt ? COMMIT : WAIT_PRESS;
      COMMIT:       state_d = WAIT_RELEASE;
      WAIT_RELEASE: state_d = deb_q ? RUN : WAIT_RELEASE;
      HALTED:       state_d = HALTED;
      default:      state_d = RUN;
    endcase
  end

  // Reset state is RUN, so the RUN-derived outputs are gated to stay low in reset.
  assign in_run     = reset_n & (state_q == RUN) & ~halt;
  assign pc_enable  = (in_run & enable_clock[0]) | (state_q == COMMIT);
  assign out_strobe = in_run & (enable_clock == 2'd2);
  assign commit     = (state_q == COMMIT);
  assign waiting    = (state_q == WAIT_PRESS);
  assign halted     = (state_q == HALTED);
endmodule

// File: tb/tb_controlador_execucao.sv
// tb_controlador_execucao: directed checks of run, IN/OUT stall, debounce, halt and reset.
module tb_controlador_execucao;
  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] enable_clock = 2'd1;
  logic       halt = 1'b0;
  logic       button = 1'b1;
  logic       pc_enable, commit, out_strobe, waiting, halted;
  int         checks = 0;
  int         failures = 0;

  controlador_execucao #(.DEBOUNCE_CYCLES(4)) dut (
    .clock(clock), .reset_n(reset_n), .enable_clock(enable_clock), .halt(halt),
    .button(button), .pc_enable(pc_enable), .commit(commit), .out_strobe(out_strobe),
    .waiting(waiting), .halted(halted)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic hold(input logic b, input int n, output int commits, output int first);
    button = b;
    commits = 0;
    first = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (commit) begin
        commits++;
        if (first == 0) first = i + 1;
      end
    end
  endtask

  task automatic wait_run(output int n);
    enable_clock = 2'd1;
    n = 0;
    #1;
    while (!pc_enable && n < 40) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int c, f, n, tot, bad;
    #2;
    chk("reset_outputs", {pc_enable, commit, out_strobe, waiting, halted}, 0);
    tick();
    reset_n = 1'b1;
    #1;
    chk("run_after_reset", pc_enable, 1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if ({pc_enable, commit, waiting, halted} !== 4'b1000) bad++;
    end
    chk("free_run", bad, 0);

    enable_clock = 2'd0;
    #1;
    chk("in_stall_onset_pc", pc_enable, 0);
    chk("in_stall_onset_strobe", out_strobe, 0);
    tick();
    chk("in_waiting", waiting, 1);
    button = 1'b0;
    c = 0; f = 0; bad = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (pc_enable !== commit) bad++;
      if (f == 0 && waiting !== 1'b1 && !commit) bad++;
      if (commit) begin
        c++;
        if (f == 0) f = i;
      end
    end
    chk("in_commit_cycle", f, 7);
    chk("in_commit_count", c, 1);
    chk("in_pc_gating", bad, 0);
    button = 1'b1;
    wait_run(n);
    chk("in_release_latency", n, 7);

    enable_clock = 2'd0;
    tick();
    tot = 0;
    for (int k = 0; k < 5; k++) begin
      hold(0, 3, c, f); tot += c;
      hold(1, 2, c, f); tot += c;
    end
    chk("bounce_rejected", tot, 0);
    chk("bounce_still_waiting", waiting, 1);
    hold(0, 10, c, f);
    chk("bounce_long_commit", c, 1);
    chk("bounce_long_cycle", f, 7);
    button = 1'b1;
    wait_run(n);
    chk("bounce_back_to_run", n, 7);

    enable_clock = 2'd2;
    #1;
    chk("out_strobe_pulse", out_strobe, 1);
    chk("out_stall_pc", pc_enable, 0);
    tick();
    chk("out_strobe_gone", out_strobe, 0);
    chk("out_waiting", waiting, 1);
    hold(0, 10, c, f);
    chk("out_commit_count", c, 1);
    button = 1'b1;
    wait_run(n);
    chk("out_back_to_run", n, 7);

    hold(0, 10, c, f);
    chk("held_run_no_commit", c, 0);
    enable_clock = 2'd0;
    tick();
    chk("held_waiting", waiting, 1);
    hold(0, 10, c, f);
    chk("held_no_commit", c, 0);
    hold(1, 10, c, f);
    chk("held_release_no_commit", c, 0);
    chk("held_still_waiting", waiting, 1);
    hold(0, 10, c, f);
    chk("held_fresh_press", c, 1);
    button = 1'b1;
    wait_run(n);
    chk("held_back_to_run", n, 7);

    halt = 1'b1;
    enable_clock = 2'd0;
    #1;
    chk("halt_pc", pc_enable, 0);
    chk("halt_strobe", out_strobe, 0);
    tick();
    halt = 1'b0;
    enable_clock = 2'd1;
    #1;
    chk("halted_flag", halted, 1);
    chk("halted_not_waiting", waiting, 0);
    bad = 0;
    for (int i = 0; i < 24; i++) begin
      button = (i % 6) < 3 ? 1'b0 : 1'b1;
      if (i >= 12) button = 1'b0;
      tick();
      if (pc_enable || commit || !halted) bad++;
    end
    chk("halted_absorbing", bad, 0);

    button = 1'b1;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    enable_clock = 2'd0;
    tick();
    chk("rst_wait_entered", waiting, 1);
    hold(0, 3, c, f);
    reset_n = 1'b0;
    enable_clock = 2'd1;
    #1;
    chk("rst_mid_outputs", {pc_enable, commit, out_strobe, waiting, halted}, 0);
    tick();
    reset_n = 1'b1;
    #1;
    chk("rst_release_pc", pc_enable, 1);
    c = 0; n = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (commit) c++;
      if (pc_enable) n++;
    end
    chk("rst_no_spurious_commit", c, 0);
    chk("rst_free_run", n, 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/controlador_execucao.md
# controlador_execucao

Execution-step controller sitting directly downstream of the control unit. It consumes the decoded `enable_clock` mode, `halt` and the raw push-button. It produces the per-cycle PC/commit enables that let the datapath run freely, stall on IN/OUT until the operator presses the button, or freeze on HALT. It also contains the button synchroniser and debouncer, so the raw board key never reaches the datapath.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required before the debounced level changes. Legal range is ≥2; 10 ms at 50 MHz.
- `clock` input 1: system clock; all state updates on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `enable_clock` input 2: mode from the control unit. 1 = run, 0 = IN wait, 2 = OUT wait, 3 = treated as 1.
- `halt` input 1: HALT decoded this cycle.
- `button` input 1: raw board key, active-low (0 = pressed), asynchronous.
- `pc_enable` output 1: PC and register-file update permitted this cycle.
- `commit` output 1: one-cycle pulse marking the cycle in which a stalled IN/OUT instruction retires.
- `out_strobe` output 1: one-cycle pulse when an OUT wait begins; used to latch the display value.
- `waiting` output 1: high while waiting for a button press.
- `halted` output 1: high in HALTED state.

## Operation
- Synchroniser: two flops on `button`, both reset to 1 (released).
- Debouncer:
  - Holds debounced level `deb` (reset 1) and counter `cnt` (reset 0).
  - If sync output equals `deb`, `cnt` ← 0.
  - Otherwise `cnt` increments. When `cnt` = `DEBOUNCE_CYCLES`−1, `deb` ← sync output and `cnt` ← 0.
  - `cnt` width is `$clog2(DEBOUNCE_CYCLES)`; it never wraps.
- Press event: `deb_prev` is a register (reset 1). `press_evt` = `deb_prev` & ~`deb`, a one-cycle pulse per debounced press.
- State machine states: RUN, WAIT_PRESS, COMMIT, WAIT_RELEASE, HALTED. Reset state is RUN.
- RUN:
  - `halt`=1: go to HALTED; `halt` has priority over `enable_clock`.
  - `enable_clock`=0: go to WAIT_PRESS.
  - `enable_clock`=2: go to WAIT_PRESS and pulse `out_strobe` this cycle.
  - Otherwise stay in RUN.
- WAIT_PRESS: on `press_evt` go to COMMIT. A button already held on entry does not count; a new press edge is required.
- COMMIT: `pc_enable`=1 and `commit`=1 for exactly one cycle, then go to WAIT_RELEASE.
- WAIT_RELEASE: when `deb`=1 go to RUN. This ensures one press retires exactly one IN/OUT instruction.
- HALTED: absorbing state; only `reset_n` exits.
- Output equations:
  - `pc_enable` = (state==RUN & `halt`==0 & `enable_clock`∈{1,3}) | state==COMMIT. This is combinational from the current state and inputs.
  - `waiting` = (state==WAIT_PRESS).
  - `halted` = (state==HALTED).
  - `commit` = (state==COMMIT).
  - `out_strobe` = (state==RUN & `halt`==0 & `enable_clock`==2).
- Reset mid-operation: asynchronous return to RUN. Synchroniser, `deb`, `deb_prev` and `cnt` are all cleared immediately, and any pending commit is discarded.

## Timing
- All outputs are 0 while `reset_n`=0.
- After reset release, RUN with `enable_clock`=1 gives `pc_enable`=1 in the same cycle.
- Stall onset: on the IN/OUT instruction's first cycle, `pc_enable`=0 in that same cycle, so the PC holds.
- Press latency:
  - Raw `button` falls before edge k.
  - `deb` falls at edge k+1+`DEBOUNCE_CYCLES`.
  - `press_evt` is high in the following cycle; state is COMMIT one edge after that.
- `commit`/`pc_enable` are high for exactly one cycle per press.
- Release latency: `deb` rises `DEBOUNCE_CYCLES`+2 edges after a stable raw release; RUN follows one edge later.
- Glitch rejection: any raw pulse shorter than `DEBOUNCE_CYCLES` cycles is ignored, including when `halt` and `enable_clock`=0 arrive in the same cycle (HALTED wins).

## Test plan
- Use `DEBOUNCE_CYCLES`=4 throughout.
- **Free run**: reset, `enable_clock`=1 for 10 cycles → `pc_enable`=1 every cycle; `commit`, `waiting`, `halted` stay 0.
- **IN stall**: `enable_clock`=0, then hold `button`=0 for 20 cycles → `pc_enable`=0 and `waiting`=1 until `commit` pulses exactly once, 7 cycles after the fall (±1 per Timing). No further commit while held. RUN is re-entered after release plus 7 cycles.
- **Bounce**: in WAIT_PRESS, raw pulses of 3 cycles low / 2 cycles high ×5 → no `commit`. Then 10 cycles low → one `commit`.
- **OUT**: `enable_clock`=2 in RUN → `out_strobe` high for 1 cycle, `waiting`=1 next cycle. A press then yields one `commit`.
- **Held button / halt priority**: button already held when `enable_clock`=0 arrives → no commit until release and a fresh press. Separately, `halt`=1 together with `enable_clock`=0 → `halted`=1, `pc_enable`=0 indefinitely regardless of button activity.
- **Reset mid-wait**: assert `reset_n`=0 during WAIT_PRESS with button held → outputs are 0 immediately. After release with `enable_clock`=1, `pc_enable`=1 and no spurious `commit`.
